// File: rtl/timer_countdown_bcd_if.sv
// Control and display bundle for timer_countdown_bcd.
// TIMER_COUNT_UP_EN adds the i_count_up direction select.
interface timer_countdown_bcd_if;
    logic       i_load;
    logic       i_start;
    logic       i_stop;
    logic [3:0] i_load_min_tens;
    logic [3:0] i_load_min_ones;
    logic [3:0] i_load_sec_tens;
    logic [3:0] i_load_sec_ones;
`ifdef TIMER_COUNT_UP_EN
    logic       i_count_up;
`endif
    logic [3:0] o_min_tens;
    logic [3:0] o_min_ones;
    logic [3:0] o_sec_tens;
    logic [3:0] o_sec_ones;
    logic       o_running;
    logic       o_done;

    modport slave (
        input  i_load, i_start, i_stop,
        input  i_load_min_tens, i_load_min_ones, i_load_sec_tens, i_load_sec_ones,
`ifdef TIMER_COUNT_UP_EN
        input  i_count_up,
`endif
        output o_min_tens, o_min_ones, o_sec_tens, o_sec_ones, o_running, o_done
    );

    modport master (
        output i_load, i_start, i_stop,
        output i_load_min_tens, i_load_min_ones, i_load_sec_tens, i_load_sec_ones,
`ifdef TIMER_COUNT_UP_EN
        output i_count_up,
`endif
        input  o_min_tens, o_min_ones, o_sec_tens, o_sec_ones, o_running, o_done
    );
endinterface

// File: rtl/timer_countdown_bcd.sv
// MM:SS BCD countdown driven by rising edges of a divided clock sampled as data.
// Optional macro TIMER_COUNT_UP_EN enables counting up to 99:59.
module timer_countdown_bcd #(
    parameter int TICKS_PER_SEC = 1
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_tick_clk,
    timer_countdown_bcd_if.slave   bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

    state_t     r_state, w_state_nxt;
    logic       r_prev;
    logic [7:0] r_pre, w_pre_nxt;
    logic [3:0] r_mt, r_mo, r_st, r_so;
    logic [3:0] w_mt_nxt, w_mo_nxt, w_st_nxt, w_so_nxt;
    logic [3:0] w_ld_mt, w_ld_mo, w_ld_st, w_ld_so;
    logic [3:0] w_dec_mt, w_dec_mo, w_dec_st, w_dec_so;
    logic       w_tick, w_step, w_nz, w_dec_zero;

    assign w_tick = i_tick_clk & ~r_prev;
    assign w_step = w_tick && (r_pre == 8'(TICKS_PER_SEC - 1));
    assign w_nz   = |{r_mt, r_mo, r_st, r_so};

    assign w_ld_mt = (bus.i_load_min_tens > 4'd9) ? 4'd9 : bus.i_load_min_tens;
    assign w_ld_mo = (bus.i_load_min_ones > 4'd9) ? 4'd9 : bus.i_load_min_ones;
    assign w_ld_st = (bus.i_load_sec_tens > 4'd5) ? 4'd5 : bus.i_load_sec_tens;
    assign w_ld_so = (bus.i_load_sec_ones > 4'd9) ? 4'd9 : bus.i_load_sec_ones;

    // Borrow chain; only used while RUN, where the value is never 00:00.
    always_comb begin
        w_dec_mt = r_mt;
        w_dec_mo = r_mo;
        w_dec_st = r_st;
        w_dec_so = r_so - 4'd1;
        if (r_so == 4'd0) begin
            w_dec_so = 4'd9;
            w_dec_st = r_st - 4'd1;
            if (r_st == 4'd0) begin
                w_dec_st = 4'd5;
                w_dec_mo = r_mo - 4'd1;
                if (r_mo == 4'd0) begin
                    w_dec_mo = 4'd9;
                    w_dec_mt = r_mt - 4'd1;
                end
            end
        end
    end
    assign w_dec_zero = ~|{w_dec_mt, w_dec_mo, w_dec_st, w_dec_so};

`ifdef TIMER_COUNT_UP_EN
    logic       r_up, w_up_nxt;
    logic [3:0] w_inc_mt, w_inc_mo, w_inc_st, w_inc_so;
    logic       w_max, w_inc_max;

    assign w_max = ({r_mt, r_mo, r_st, r_so} == 16'h9959);

    always_comb begin
        w_inc_mt = r_mt;
        w_inc_mo = r_mo;
        w_inc_st = r_st;
        w_inc_so = r_so + 4'd1;
        if (r_so == 4'd9) begin
            w_inc_so = 4'd0;
            w_inc_st = r_st + 4'd1;
            if (r_st == 4'd5) begin
                w_inc_st = 4'd0;
                w_inc_mo = r_mo + 4'd1;
                if (r_mo == 4'd9) begin
                    w_inc_mo = 4'd0;
                    w_inc_mt = r_mt + 4'd1;
                end
            end
        end
    end
    assign w_inc_max = ({w_inc_mt, w_inc_mo, w_inc_st, w_inc_so} == 16'h9959);
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_pre_nxt   = r_pre;
        w_mt_nxt    = r_mt;
        w_mo_nxt    = r_mo;
        w_st_nxt    = r_st;
        w_so_nxt    = r_so;
`ifdef TIMER_COUNT_UP_EN
        w_up_nxt    = r_up;
`endif
        if (bus.i_load) begin
            {w_mt_nxt, w_mo_nxt, w_st_nxt, w_so_nxt} = {w_ld_mt, w_ld_mo, w_ld_st, w_ld_so};
            w_state_nxt = S_IDLE;
            w_pre_nxt   = 8'd0;
        end else if (bus.i_stop) begin
            if (r_state == S_RUN) w_state_nxt = S_PAUSE;
        end else if (bus.i_start) begin
            if (r_state == S_PAUSE) w_state_nxt = S_RUN;
`ifdef TIMER_COUNT_UP_EN
            else if (r_state == S_IDLE && (bus.i_count_up ? !w_max : w_nz)) begin
                w_state_nxt = S_RUN;
                w_up_nxt    = bus.i_count_up;
            end
`else
            else if (r_state == S_IDLE && w_nz) w_state_nxt = S_RUN;
`endif
        end else if (r_state == S_RUN && w_tick) begin
            if (w_step) begin
                w_pre_nxt = 8'd0;
`ifdef TIMER_COUNT_UP_EN
                if (r_up) begin
                    {w_mt_nxt, w_mo_nxt, w_st_nxt, w_so_nxt} = {w_inc_mt, w_inc_mo, w_inc_st, w_inc_so};
                    if (w_inc_max) w_state_nxt = S_DONE;
                end else
`endif
                begin
                    {w_mt_nxt, w_mo_nxt, w_st_nxt, w_so_nxt} = {w_dec_mt, w_dec_mo, w_dec_st, w_dec_so};
                    if (w_dec_zero) w_state_nxt = S_DONE;
                end
            end else begin
                w_pre_nxt = r_pre + 8'd1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_prev  <= 1'b0;
            r_pre   <= 8'd0;
            r_mt    <= 4'd0;
            r_mo    <= 4'd0;
            r_st    <= 4'd0;
            r_so    <= 4'd0;
`ifdef TIMER_COUNT_UP_EN
            r_up    <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_prev  <= i_tick_clk;
            r_pre   <= w_pre_nxt;
            r_mt    <= w_mt_nxt;
            r_mo    <= w_mo_nxt;
            r_st    <= w_st_nxt;
            r_so    <= w_so_nxt;
`ifdef TIMER_COUNT_UP_EN
            r_up    <= w_up_nxt;
`endif
        end
    end

    assign bus.o_min_tens = r_mt;
    assign bus.o_min_ones = r_mo;
    assign bus.o_sec_tens = r_st;
    assign bus.o_sec_ones = r_so;
    assign bus.o_running  = (r_state == S_RUN);
    assign bus.o_done     = (r_state == S_DONE);
endmodule

// File: tb/tb_timer_countdown_bcd.sv
// Bench for timer_countdown_bcd: two instances (TICKS_PER_SEC 1 and 4) against a seconds-based model.
module tb_timer_countdown_bcd;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, tc, load, start, stop;
    logic [3:0] lmt, lmo, lst, lso;

    timer_countdown_bcd_if ifc0 ();
    timer_countdown_bcd_if ifc1 ();

    assign ifc0.i_load = load;  assign ifc1.i_load = load;
    assign ifc0.i_start = start; assign ifc1.i_start = start;
    assign ifc0.i_stop = stop;  assign ifc1.i_stop = stop;
    assign ifc0.i_load_min_tens = lmt; assign ifc1.i_load_min_tens = lmt;
    assign ifc0.i_load_min_ones = lmo; assign ifc1.i_load_min_ones = lmo;
    assign ifc0.i_load_sec_tens = lst; assign ifc1.i_load_sec_tens = lst;
    assign ifc0.i_load_sec_ones = lso; assign ifc1.i_load_sec_ones = lso;
`ifdef TIMER_COUNT_UP_EN
    assign ifc0.i_count_up = 1'b0; assign ifc1.i_count_up = 1'b0;
`endif

    timer_countdown_bcd #(.TICKS_PER_SEC(1)) dut0 (.i_clk(clk), .i_reset(rst), .i_tick_clk(tc), .bus(ifc0));
    timer_countdown_bcd #(.TICKS_PER_SEC(4)) dut1 (.i_clk(clk), .i_reset(rst), .i_tick_clk(tc), .bus(ifc1));

    logic [17:0] obs0, obs1;
    assign obs0 = {ifc0.o_min_tens, ifc0.o_min_ones, ifc0.o_sec_tens, ifc0.o_sec_ones, ifc0.o_running, ifc0.o_done};
    assign obs1 = {ifc1.o_min_tens, ifc1.o_min_ones, ifc1.o_sec_tens, ifc1.o_sec_ones, ifc1.o_running, ifc1.o_done};

    // Model: value as total seconds; state 0 idle, 1 run, 2 pause, 3 done.
    int secs [2], mst [2], pre [2];
    int tps [2] = '{1, 4};
    bit prev;
    int n_chk = 0, n_fail = 0;

    function automatic logic [15:0] bcd(int s);
        return {4'(s / 600), 4'((s / 60) % 10), 4'((s % 60) / 10), 4'(s % 10)};
    endfunction

    function automatic logic [17:0] expv(int k);
        return {bcd(secs[k]), mst[k] == 1, mst[k] == 3};
    endfunction

    function automatic int clampd(int d, int mx);
        return (d > mx) ? mx : d;
    endfunction

    task automatic chk(string tag, logic [17:0] obs, logic [17:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit tick;
        tick = tc && !prev;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                secs[k] = 0; mst[k] = 0; pre[k] = 0;
            end else if (load) begin
                secs[k] = clampd(lmt, 9) * 600 + clampd(lmo, 9) * 60 + clampd(lst, 5) * 10 + clampd(lso, 9);
                mst[k] = 0; pre[k] = 0;
            end else if (stop) begin
                if (mst[k] == 1) mst[k] = 2;
            end else if (start) begin
                if ((mst[k] == 0 && secs[k] != 0) || mst[k] == 2) mst[k] = 1;
            end else if (mst[k] == 1 && tick) begin
                if (pre[k] == tps[k] - 1) begin
                    pre[k] = 0;
                    secs[k]--;
                    if (secs[k] == 0) mst[k] = 3;
                end else pre[k]++;
            end
        end
        prev = rst ? 1'b0 : tc;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        chk("tps1", obs0, expv(0));
        chk("tps4", obs1, expv(1));
    endtask

    task automatic slow(int n);
        repeat (n) begin
            tc = 1'b1; repeat (4) cyc();
            tc = 1'b0; repeat (4) cyc();
        end
    endtask

    task automatic do_load(logic [15:0] v);
        {lmt, lmo, lst, lso} = v;
        load = 1'b1; cyc(); load = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1; cyc(); start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; tc = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0;
        {lmt, lmo, lst, lso} = 16'h0;
        prev = 1'b0;
        for (int k = 0; k < 2; k++) begin secs[k] = 0; mst[k] = 0; pre[k] = 0; end
        cyc(); cyc();
        chk("reset", obs0, 18'h0);
        rst = 1'b0;

        do_load(16'h0003); pulse_start();
        slow(1); chk("cd_0002", obs0, {16'h0002, 2'b10});
        slow(1); chk("cd_0001", obs0, {16'h0001, 2'b10});
        slow(1); chk("cd_done", obs0, {16'h0000, 2'b01});

        do_load(16'h1000); pulse_start();
        slow(1);  chk("borrow_0959", obs0, {16'h0959, 2'b10});
        slow(60); chk("borrow_0859", obs0, {16'h0859, 2'b10});

        do_load(16'h0005); pulse_start();
        tc = 1'b1; stop = 1'b1; cyc(); stop = 1'b0;
        repeat (3) cyc(); tc = 1'b0; repeat (4) cyc();
        chk("stop_tick", obs0, {16'h0005, 2'b00});
        slow(2); chk("pause_hold", obs0, {16'h0005, 2'b00});
        pulse_start(); slow(1);
        chk("resume", obs0, {16'h0004, 2'b10});

        do_load(16'h7A6F); chk("clamp", obs0, {16'h7959, 2'b00});
        do_load(16'h0000); pulse_start(); cyc();
        chk("start_zero", obs0, 18'h0);

        do_load(16'h0002); pulse_start();
        slow(2); chk("pre4_partial", obs1, {16'h0002, 2'b10});
        stop = 1'b1; cyc(); stop = 1'b0;
        slow(3); pulse_start();
        slow(1); chk("pre4_3rd", obs1, {16'h0002, 2'b10});
        slow(1); chk("pre4_step", obs1, {16'h0001, 2'b10});

        do_load(16'h0030); pulse_start(); slow(2);
        rst = 1'b1; cyc(); rst = 1'b0;
        chk("reset_run", obs0, 18'h0);
        do_load(16'h0001); pulse_start(); slow(1);
        chk("done1", obs0, {16'h0000, 2'b01});
        pulse_start(); cyc();
        chk("done_start", obs0, {16'h0000, 2'b01});
        do_load(16'h0010);
        chk("done_load", obs0, {16'h0010, 2'b00});

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(2) == 0) tc = ~tc;
            load  = ($urandom_range(79) == 0);
            {lmt, lmo, lst, lso} = 16'($urandom_range(16'hFFFF));
            if ($urandom_range(1) == 0) {lmt, lmo} = 8'h00;
            stop  = ($urandom_range(24) == 0);
            start = ($urandom_range(9) == 0);
            rst   = ($urandom_range(499) == 0);
            cyc();
        end
        rst = 1'b0; load = 1'b0; stop = 1'b0; start = 1'b0;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
